// File: rtl/systolic_col_accumulator_pkg.sv
// Shared definitions for the systolic column accumulator: FP32 constants,
// FSM state encoding and the lane slice helper.
package systolic_col_accumulator_pkg;

    localparam int unsigned FP32_W = 32;

    localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Low bit of lane k inside a flat lane-packed bus
    function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_col_accumulator_acc_lane.sv
// One accumulator lane: FP32 adder, lane register, clear and snapshot tap.
// ACC_STATUS_EN adds a sticky inf/NaN flag per lane.
module systolic_col_accumulator_acc_lane
    import systolic_col_accumulator_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [FP32_W-1:0] in_lane,
    input  logic              acc_clear,
    output logic [FP32_W-1:0] snap_c
`ifdef ACC_STATUS_EN
    ,
    output logic              sticky_q,
    output logic              snap_exc_c
`endif
);

    logic [FP32_W-1:0] lane_q;
    logic [FP32_W-1:0] lane_d;
    logic [FP32_W-1:0] sum_c;

    // FP32 add, round-to-nearest-even, denormals flushed to +0, canonical qNaN
    function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
        logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [31:0]       big, sml, res;
        logic [26:0]       mbig, msml, mshift, norm;
        logic [7:0]        d;
        logic              sticky, found;
        logic [27:0]       sum;
        logic signed [9:0] e;
        logic [4:0]        lz;
        logic [24:0]       rnd;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        res    = FP32_ZERO;
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
            res = FP32_QNAN;
        end else if (a_inf) begin
            res = {a[31], 8'hFF, 23'd0};
        end else if (b_inf) begin
            res = {b[31], 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
            res = FP32_ZERO;
        end else if (a_zero) begin
            res = b;
        end else if (b_zero) begin
            res = a;
        end else begin
            if (a[30:0] >= b[30:0]) begin
                big = a;
                sml = b;
            end else begin
                big = b;
                sml = a;
            end
            mbig = {1'b1, big[22:0], 3'b000};
            msml = {1'b1, sml[22:0], 3'b000};
            d    = big[30:23] - sml[30:23];
            if (d >= 8'd27) begin
                mshift = 27'd0;
                sticky = 1'b1;
            end else begin
                mshift = msml >> d;
                sticky = |(msml & ((27'd1 << d) - 27'd1));
            end
            mshift[0] = mshift[0] | sticky;
            e = 10'(big[30:23]);
            if (big[31] == sml[31]) begin
                sum = {1'b0, mbig} + {1'b0, mshift};
                if (sum[27]) begin
                    norm    = sum[27:1];
                    norm[0] = norm[0] | sum[0];
                    e       = e + 10'sd1;
                end else begin
                    norm = sum[26:0];
                end
            end else begin
                sum  = {1'b0, mbig} - {1'b0, mshift};
                norm = sum[26:0];
            end
            if (norm == 27'd0) begin
                res = FP32_ZERO;
            end else begin
                lz    = 5'd0;
                found = 1'b0;
                for (int i = 26; i >= 0; i--) begin
                    if (!found) begin
                        if (norm[i]) found = 1'b1;
                        else         lz    = lz + 5'd1;
                    end
                end
                norm = norm << lz;
                e    = e - 10'(lz);
                rnd  = {1'b0, norm[26:3]} + 25'(norm[2] & (norm[1] | norm[0] | norm[3]));
                if (rnd[24]) begin
                    rnd = rnd >> 1;
                    e   = e + 10'sd1;
                end
                if (e >= 10'sd255)    res = {big[31], 8'hFF, 23'd0};
                else if (e <= 10'sd0) res = FP32_ZERO;
                else                  res = {big[31], e[7:0], rnd[22:0]};
            end
        end
        return res;
    endfunction

    // Post-add value feeds both the snapshot and the next lane value
    always_comb begin
        sum_c  = fp32_add(lane_q, in_lane);
        snap_c = in_valid ? sum_c : lane_q;
        lane_d = acc_clear ? FP32_ZERO : snap_c;
    end

    // Lane register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lane_q <= FP32_ZERO;
        else     lane_q <= lane_d;
    end

`ifdef ACC_STATUS_EN
    logic sticky_d;

    // Sticky flag sets on any inf/NaN add result, clears with the lane
    always_comb begin
        snap_exc_c = sticky_q | (in_valid && (sum_c[30:23] == 8'hFF));
        sticky_d   = acc_clear ? 1'b0 : snap_exc_c;
    end

    // Sticky flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sticky_q <= 1'b0;
        else     sticky_q <= sticky_d;
    end
`endif

endmodule

// File: rtl/systolic_col_accumulator.sv
// Column accumulator at the bottom edge of the systolic array: per-lane FP32
// accumulation, snapshot on store, and a word-by-word drain to the output
// buffer. Optional macro ACC_STATUS_EN adds sticky_exc / out_exc.
module systolic_col_accumulator
    import systolic_col_accumulator_pkg::*;
#(
    parameter int unsigned ARR_SIZE = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ARR_SIZE*DATA_W-1:0] in_data,
    input  logic                       acc_clear,
    input  logic                       store_req,
    input  logic [ADDR_W-1:0]          store_base,
    output logic                       store_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [ADDR_W-1:0]          out_addr,
    output logic                       store_done
`ifdef ACC_STATUS_EN
    ,
    output logic                       sticky_exc,
    output logic                       out_exc
`endif
);

    localparam int unsigned    IDX_W    = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARR_SIZE - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [DATA_W-1:0]  buf_q [ARR_SIZE];
    logic [DATA_W-1:0]  buf_d [ARR_SIZE];
    logic [DATA_W-1:0]  snap_c [ARR_SIZE];

`ifdef ACC_STATUS_EN
    logic [ARR_SIZE-1:0] lane_sticky;
    logic [ARR_SIZE-1:0] lane_snap_exc;
    logic                exc_buf_q, exc_buf_d;
`endif

    // Lanes never stall; only reset holds off input
    assign in_ready = ~rst;

    for (genvar k = 0; k < ARR_SIZE; k++) begin : g_lane
        systolic_col_accumulator_acc_lane u_acc_lane (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_lane    (in_data[lane_lo(k, DATA_W) +: DATA_W]),
            .acc_clear  (acc_clear),
            .snap_c     (snap_c[k])
`ifdef ACC_STATUS_EN
            ,
            .sticky_q   (lane_sticky[k]),
            .snap_exc_c (lane_snap_exc[k])
`endif
        );
    end

    // State, drain index, base address and drain buffer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            idx_q   <= '0;
            base_q  <= '0;
            for (int i = 0; i < ARR_SIZE; i++) buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            buf_q   <= buf_d;
        end
    end

    // Next state: accept a store in ACCUM, step the index on each drain handshake
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        buf_d   = buf_q;
        case (state_q)
            ACCUM: begin
                if (store_req) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                    base_d  = store_base;
                    buf_d   = snap_c;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ACCUM;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Outputs decoded from state; data/address held by registered index
    always_comb begin
        store_ready = 1'b0;
        out_valid   = 1'b0;
        store_done  = 1'b0;
        case (state_q)
            ACCUM: store_ready = 1'b1;
            DRAIN: begin
                out_valid  = 1'b1;
                store_done = out_ready && (idx_q == LAST_IDX);
            end
            default: store_ready = 1'b0;
        endcase
        out_data = buf_q[idx_q];
        out_addr = base_q + ADDR_W'(idx_q);
    end

`ifdef ACC_STATUS_EN
    // Tile exception flag captured with the snapshot
    always_comb begin
        exc_buf_d = exc_buf_q;
        if (state_q == ACCUM && store_req) exc_buf_d = |lane_snap_exc;
    end

    // Snapshot exception register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) exc_buf_q <= 1'b0;
        else     exc_buf_q <= exc_buf_d;
    end

    assign sticky_exc = |lane_sticky;
    assign out_exc    = exc_buf_q;
`endif

endmodule

// File: tb/tb_systolic_col_accumulator.sv
// Directed bench for systolic_col_accumulator (ARR_SIZE=4).
module tb_systolic_col_accumulator;

    localparam int unsigned ARR_SIZE = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 4;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic [ARR_SIZE*DATA_W-1:0] in_data = '0;
    logic                       acc_clear = 1'b0;
    logic                       store_req = 1'b0;
    logic [ADDR_W-1:0]          store_base = '0;
    logic                       store_ready;
    logic                       out_valid;
    logic                       out_ready = 1'b0;
    logic [DATA_W-1:0]          out_data;
    logic [ADDR_W-1:0]          out_addr;
    logic                       store_done;
`ifdef ACC_STATUS_EN
    logic                       sticky_exc;
    logic                       out_exc;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    systolic_col_accumulator #(
        .ARR_SIZE (ARR_SIZE),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .acc_clear   (acc_clear),
        .store_req   (store_req),
        .store_base  (store_base),
        .store_ready (store_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .store_done  (store_done)
`ifdef ACC_STATUS_EN
        ,
        .sticky_exc  (sticky_exc),
        .out_exc     (out_exc)
`endif
    );

    function automatic logic [127:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                           input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // One cycle of acc_clear with nothing else active
    task automatic clear_lanes();
        @(negedge clk);
        in_valid = 1'b0; store_req = 1'b0; acc_clear = 1'b1;
        @(negedge clk);
        acc_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        checks++; if (store_ready !== 1'b1) begin failures++; $display("FAIL reset_store_ready got=%b want=1", store_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        checks++; if (out_addr !== 4'h0) begin failures++; $display("FAIL reset_out_addr got=%h want=0", out_addr); end
        checks++; if (store_done !== 1'b0) begin failures++; $display("FAIL reset_store_done got=%b want=0", store_done); end
`ifdef ACC_STATUS_EN
        checks++; if (sticky_exc !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%b want=0", sticky_exc); end
`endif
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_accumulate();
        logic [31:0] want [4];
        want = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
        clear_lanes();
        repeat (2) begin
            in_valid = 1'b1;
            in_data  = pack4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
            @(negedge clk);
        end
        in_valid = 1'b0; store_req = 1'b1; store_base = 4'd0; out_ready = 1'b1; #1;
        checks++; if (store_ready !== 1'b1) begin failures++; $display("FAIL acc_store_ready got=%b want=1", store_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            store_req = 1'b0; #1;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL acc_valid[%0d] got=%b want=1", i, out_valid); end
            checks++; if (out_data !== want[i]) begin failures++; $display("FAIL acc_data[%0d] got=%h want=%h", i, out_data, want[i]); end
            checks++; if (out_addr !== 4'(i)) begin failures++; $display("FAIL acc_addr[%0d] got=%0d want=%0d", i, out_addr, i); end
            checks++; if (store_done !== (i == 3)) begin failures++; $display("FAIL acc_done[%0d] got=%b want=%b", i, store_done, (i == 3)); end
            checks++; if (store_ready !== 1'b0) begin failures++; $display("FAIL acc_busy[%0d] got=%b want=0", i, store_ready); end
        end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL acc_valid_drop got=%b want=0", out_valid); end
        checks++; if (store_done !== 1'b0) begin failures++; $display("FAIL acc_done_drop got=%b want=0", store_done); end
        checks++; if (store_ready !== 1'b1) begin failures++; $display("FAIL acc_ready_back got=%b want=1", store_ready); end
    endtask

    task automatic test_clear_store();
        logic [31:0] want [4];
        want = '{32'h40400000, 32'h40C00000, 32'h41100000, 32'h41400000};
        // lanes still hold {2,4,6,8}; store+clear+beat in one cycle
        @(negedge clk);
        store_req = 1'b1; acc_clear = 1'b1; in_valid = 1'b1; store_base = 4'd0; out_ready = 1'b1;
        in_data   = pack4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            store_req = 1'b0; acc_clear = 1'b0; in_valid = 1'b0; #1;
            checks++; if (out_data !== want[i]) begin failures++; $display("FAIL clr_data[%0d] got=%h want=%h", i, out_data, want[i]); end
        end
        @(negedge clk);
        store_req = 1'b1; store_base = 4'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            store_req = 1'b0; #1;
            checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL clr_zero_data[%0d] got=%h want=0", i, out_data); end
            checks++; if (out_addr !== 4'(4 + i)) begin failures++; $display("FAIL clr_zero_addr[%0d] got=%0d want=%0d", i, out_addr, 4 + i); end
        end
    endtask

    task automatic test_wrap_round();
        logic [31:0] want [4];
        want = '{32'h3F800002, 32'h00000000, 32'h40400000, 32'h40000000};
        clear_lanes();
        in_valid = 1'b1;
        in_data  = pack4(32'h3F800001, 32'hBF800000, 32'h3FC00000, 32'h40A00000);
        @(negedge clk);
        in_data  = pack4(32'h33800000, 32'h3F800000, 32'h3FC00000, 32'hC0400000);
        @(negedge clk);
        in_valid = 1'b0; store_req = 1'b1; store_base = 4'd14; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            store_req = 1'b0; #1;
            checks++; if (out_data !== want[i]) begin failures++; $display("FAIL wrap_data[%0d] got=%h want=%h", i, out_data, want[i]); end
            checks++; if (out_addr !== 4'(14 + i)) begin failures++; $display("FAIL wrap_addr[%0d] got=%0d want=%0d", i, out_addr, 4'(14 + i)); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] want [4];
        int hs;
        int dones;
        want  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        hs    = 0;
        dones = 0;
        clear_lanes();
        in_valid = 1'b1;
        in_data  = pack4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        @(negedge clk);
        in_valid = 1'b0; store_req = 1'b1; store_base = 4'd3;
        for (int s = 0; s < 12 && hs < 4; s++) begin
            @(negedge clk);
            store_req = 1'b0;
            out_ready = (s % 2 == 0); #1;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b want=1", s, out_valid); end
            checks++; if (out_data !== want[hs]) begin failures++; $display("FAIL stall_data[%0d] got=%h want=%h", s, out_data, want[hs]); end
            checks++; if (out_addr !== 4'(3 + hs)) begin failures++; $display("FAIL stall_addr[%0d] got=%0d want=%0d", s, out_addr, 3 + hs); end
            checks++; if (store_done !== (out_ready && hs == 3)) begin failures++; $display("FAIL stall_done[%0d] got=%b want=%b", s, store_done, (out_ready && hs == 3)); end
            if (store_done) dones++;
            if (out_ready) hs++;
        end
        checks++; if (hs != 4) begin failures++; $display("FAIL stall_handshakes got=%0d want=4", hs); end
        checks++; if (dones != 1) begin failures++; $display("FAIL stall_done_count got=%0d want=1", dones); end
        @(negedge clk);
        out_ready = 1'b1; #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_end_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want1 [4];
        logic [31:0] want2 [4];
        want1 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        want2 = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
        clear_lanes();
        in_valid = 1'b1;
        in_data  = pack4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        @(negedge clk);
        in_valid = 1'b0; store_req = 1'b1; store_base = 4'd0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid   = (i == 0);
            in_data    = pack4(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
            store_base = 4'd8; #1;
            checks++; if (store_ready !== 1'b0) begin failures++; $display("FAIL b2b_busy[%0d] got=%b want=0", i, store_ready); end
            checks++; if (out_data !== want1[i]) begin failures++; $display("FAIL b2b_first_data[%0d] got=%h want=%h", i, out_data, want1[i]); end
            checks++; if (out_addr !== 4'(i)) begin failures++; $display("FAIL b2b_first_addr[%0d] got=%0d want=%0d", i, out_addr, i); end
            checks++; if (store_done !== (i == 3)) begin failures++; $display("FAIL b2b_first_done[%0d] got=%b want=%b", i, store_done, (i == 3)); end
        end
        @(negedge clk);
        in_valid = 1'b0; #1;
        checks++; if (store_ready !== 1'b1) begin failures++; $display("FAIL b2b_gap_ready got=%b want=1", store_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap_valid got=%b want=0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            store_req = 1'b0; #1;
            checks++; if (out_data !== want2[i]) begin failures++; $display("FAIL b2b_second_data[%0d] got=%h want=%h", i, out_data, want2[i]); end
            checks++; if (out_addr !== 4'(8 + i)) begin failures++; $display("FAIL b2b_second_addr[%0d] got=%0d want=%0d", i, out_addr, 8 + i); end
            checks++; if (store_done !== (i == 3)) begin failures++; $display("FAIL b2b_second_done[%0d] got=%b want=%b", i, store_done, (i == 3)); end
        end
    endtask

    task automatic test_reset_mid_drain();
        clear_lanes();
        in_valid = 1'b1;
        in_data  = pack4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        @(negedge clk);
        in_valid = 1'b0; store_req = 1'b1; store_base = 4'd5; out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            store_req = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1; #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rstmid_data got=%h want=0", out_data); end
        checks++; if (out_addr !== 4'h0) begin failures++; $display("FAIL rstmid_addr got=%0d want=0", out_addr); end
        checks++; if (store_done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b want=0", store_done); end
        checks++; if (store_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b want=1", store_ready); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_in_ready got=%b want=0", in_ready); end
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_after_valid got=%b want=0", out_valid); end
        @(negedge clk);
        store_req = 1'b1; store_base = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            store_req = 1'b0; #1;
            checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rstmid_lane_zero[%0d] got=%h want=0", i, out_data); end
        end
    endtask

`ifdef ACC_STATUS_EN
    task automatic test_status();
        clear_lanes();
        in_valid = 1'b1;
        in_data  = pack4(32'h7F800000, 32'h3F800000, 32'h0, 32'h0);
        @(negedge clk);
        in_valid = 1'b0; #1;
        checks++; if (sticky_exc !== 1'b1) begin failures++; $display("FAIL status_set got=%b want=1", sticky_exc); end
        store_req = 1'b1; store_base = 4'd0; out_ready = 1'b1;
        @(negedge clk);
        store_req = 1'b0; #1;
        checks++; if (out_exc !== 1'b1) begin failures++; $display("FAIL status_out_exc got=%b want=1", out_exc); end
        checks++; if (out_data !== 32'h7F800000) begin failures++; $display("FAIL status_inf_data got=%h want=7f800000", out_data); end
        repeat (3) @(negedge clk);
        acc_clear = 1'b1;
        @(negedge clk);
        acc_clear = 1'b0; #1;
        checks++; if (sticky_exc !== 1'b0) begin failures++; $display("FAIL status_clear got=%b want=0", sticky_exc); end
    endtask
`endif

    initial begin
        test_reset();
        test_accumulate();
        test_clear_store();
        test_wrap_round();
        test_stall();
        test_back_to_back();
        test_reset_mid_drain();
`ifdef ACC_STATUS_EN
        test_status();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
